// File: rtl/mult_pkg.sv
// mult_pkg -- definitions shared by the FP32 multiplier normaliser and rounder.
//   state_t      : normaliser sequencing states {IDLE, MULT, NORM, DONE}
//   round_values : rounding-mode encoding used by round_mult
//   MANT_W, PROD_W, BIAS, EXP_W : datapath constants
//   unpack_mant  : IEEE-754 single significand with the hidden bit restored
package mult_pkg;

  localparam int MANT_W = 24;
  localparam int PROD_W = 48;
  localparam int BIAS   = 127;
  localparam int EXP_W  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    RND_NEAREST_EVEN = 3'd0,
    RND_TO_ZERO      = 3'd1,
    RND_UP           = 3'd2,
    RND_DOWN         = 3'd3,
    RND_NEAREST_MAX  = 3'd4
  } round_values;

  // Hidden bit is 1 for any non-zero exponent field; denormals/zero get 0.
  function automatic logic [MANT_W-1:0] unpack_mant(input logic [31:0] x);
    return {(x[30:23] != 8'd0), x[22:0]};
  endfunction

endpackage

// File: rtl/mant_seq_mult.sv
// mant_seq_mult -- iterative radix-2 shift-add significand multiplier.
//   clk, rst (sync, active-high)
//   start   : load ma/mb and clear the accumulator (one-cycle pulse)
//   ma, mb  : W-bit unsigned operands
//   done    : high during the last of the W iteration cycles
//   product : 2W-bit result, valid the cycle after done
module mant_seq_mult #(
  parameter int W = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   ma,
  input  logic [W-1:0]   mb,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W);

  logic [W-1:0]   ma_reg;
  logic [W-1:0]   mb_reg;
  logic [2*W-1:0] acc_reg;
  logic [CW-1:0]  count_reg;
  logic           run_reg;
  logic [W:0]     sum;

  // Partial sum keeps its carry bit; it lands in the accumulator MSB after
  // the right shift, so nothing is lost across iterations.
  always_comb begin
    sum = {1'b0, acc_reg[2*W-1:W]} + (mb_reg[0] ? {1'b0, ma_reg} : '0);
  end

  assign done    = run_reg && (count_reg == CW'(W - 1));
  assign product = acc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ma_reg    <= '0;
      mb_reg    <= '0;
      acc_reg   <= '0;
      count_reg <= '0;
      run_reg   <= 1'b0;
    end else if (start) begin
      ma_reg    <= ma;
      mb_reg    <= mb;
      acc_reg   <= '0;
      count_reg <= '0;
      run_reg   <= 1'b1;
    end else if (run_reg) begin
      acc_reg <= {sum, acc_reg[W-1:1]};
      mb_reg  <= mb_reg >> 1;
      if (done) begin
        run_reg   <= 1'b0;
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_normalizer.sv
// mult_normalizer -- FP32 multiplier front end feeding round_mult.
// Unpacks a/b, multiplies significands over 24 cycles, normalises the
// 48-bit product and holds the result under a valid/ready handshake.
//   clk, rst (sync, active-high)
//   in_valid/in_ready   : operand handshake (accept only in IDLE)
//   a, b                : IEEE-754 single operands
//   out_valid/out_ready : result handshake
//   norm_exponent       : 10-bit biased exponent, two's-complement range
//   norm_mantissa       : normalised 1.xxx significand
//   guard, sticky, sign : rounding side information
// Optional build macro MULT_NORM_EARLY_ZERO_EN: a zero exponent field on
// either operand bypasses the multiply and reports all-zero fields at t+2.
module mult_normalizer #(
  parameter int MANT_W = 24,
  parameter int BIAS   = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [9:0]        norm_exponent,
  output logic [MANT_W-1:0] norm_mantissa,
  output logic              guard,
  output logic              sticky,
  output logic              sign
);
  import mult_pkg::*;

  localparam int P_W = 2 * MANT_W;

  state_t            state_reg, state_next;
  logic [9:0]        exp_sum_reg;
  logic              sign_hold_reg;
  logic              zero_reg;
  logic [9:0]        exponent_reg;
  logic [MANT_W-1:0] mantissa_reg;
  logic              guard_reg, sticky_reg, sign_reg;

  logic              accept, skip, mult_start, mult_done;
  logic [9:0]        exp_in;
  logic [P_W-1:0]    prod;
  logic [MANT_W-1:0] mant_n;
  logic              guard_n, sticky_n;
  logic [9:0]        exp_n;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid && (state_reg == IDLE);

`ifdef MULT_NORM_EARLY_ZERO_EN
  assign skip = (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
`else
  assign skip = 1'b0;
`endif

  assign mult_start = accept && !skip;
  // Bias is removed once here; 10 bits keep over/underflow visible downstream.
  assign exp_in = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'(BIAS);

  mant_seq_mult #(.W(MANT_W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (mult_start),
    .ma      (unpack_mant(a)),
    .mb      (unpack_mant(b)),
    .done    (mult_done),
    .product (prod)
  );

  // Product of two 1.x significands lies in [1,4): at most one bit of shift.
  always_comb begin
    if (prod[P_W-1]) begin
      mant_n   = prod[P_W-1 -: MANT_W];
      guard_n  = prod[MANT_W-1];
      sticky_n = |prod[MANT_W-2:0];
      exp_n    = exp_sum_reg + 10'd1;
    end else begin
      mant_n   = prod[P_W-2 -: MANT_W];
      guard_n  = prod[MANT_W-2];
      sticky_n = |prod[MANT_W-3:0];
      exp_n    = exp_sum_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = skip ? NORM : MULT;
      MULT: if (mult_done) state_next = NORM;
      NORM: state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      exp_sum_reg   <= '0;
      sign_hold_reg <= 1'b0;
      zero_reg      <= 1'b0;
      exponent_reg  <= '0;
      mantissa_reg  <= '0;
      guard_reg     <= 1'b0;
      sticky_reg    <= 1'b0;
      sign_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        exp_sum_reg   <= exp_in;
        sign_hold_reg <= a[31] ^ b[31];
        zero_reg      <= skip;
      end
      // Output fields change only here, so they stay frozen through DONE.
      if (state_reg == NORM) begin
        sign_reg <= sign_hold_reg;
        if (zero_reg) begin
          exponent_reg <= '0;
          mantissa_reg <= '0;
          guard_reg    <= 1'b0;
          sticky_reg   <= 1'b0;
        end else begin
          exponent_reg <= exp_n;
          mantissa_reg <= mant_n;
          guard_reg    <= guard_n;
          sticky_reg   <= sticky_n;
        end
      end
    end
  end

  assign norm_exponent = exponent_reg;
  assign norm_mantissa = mantissa_reg;
  assign guard         = guard_reg;
  assign sticky        = sticky_reg;
  assign sign          = sign_reg;

endmodule

// File: tb/tb_mult_normalizer.sv
module tb_mult_normalizer;

  typedef struct packed {
    logic [9:0]  e;
    logic [23:0] m;
    logic        g;
    logic        s;
    logic        sg;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  norm_exponent;
  logic [23:0] norm_mantissa;
  logic        guard, sticky, sign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_normalizer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .norm_exponent (norm_exponent),
    .norm_mantissa (norm_mantissa),
    .guard         (guard),
    .sticky        (sticky),
    .sign          (sign)
  );

  // Reference: exact integer product, then pick the 24 leading bits by
  // magnitude and derive guard/sticky from the remainder.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    res_t        r;
    logic [63:0] mx, my, p, rem;
    int          ex, ey, e, sh;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = 64'(x[22:0]) + ((ex != 0) ? 64'h80_0000 : 64'h0);
    my = 64'(y[22:0]) + ((ey != 0) ? 64'h80_0000 : 64'h0);
    p  = mx * my;
    e  = ex + ey - 127;
    r.sg = x[31] ^ y[31];
`ifdef MULT_NORM_EARLY_ZERO_EN
    if (ex == 0 || ey == 0) begin
      r.e = '0; r.m = '0; r.g = 1'b0; r.s = 1'b0;
      return r;
    end
`endif
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    if (sh == 24) e = e + 1;
    r.m = 24'(p >> sh);
    rem = p % (64'd1 << sh);
    r.g = (rem >= (64'd1 << (sh - 1)));
    r.s = (rem % (64'd1 << (sh - 1))) != 0;
    r.e = 10'(e);
    return r;
  endfunction

  function automatic int want_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef MULT_NORM_EARLY_ZERO_EN
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return 2;
`endif
    return 26;
  endfunction

  function automatic logic [31:0] rand_normal();
    logic [31:0] v;
    v = $urandom;
    v[30:23] = 8'($urandom_range(1, 254));
    return v;
  endfunction

  // One full transaction: accept, wait for the result, hold under
  // backpressure, then release with a one-cycle out_ready pulse.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input res_t want, input int hold, input string tag);
    res_t got;
    int   lat;
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready_before_accept: got %b want 1", tag, in_ready);
    end
    @(posedge clk); #1;
    // Junk offered while busy must be ignored.
    a = $urandom; b = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s in_ready_busy: got %b want 0 at cycle %0d", tag, in_ready, lat);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    checks++;
    if (lat != want_lat(av, bv)) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, want_lat(av, bv));
    end
    got = {norm_exponent, norm_mantissa, guard, sticky, sign};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s fields: got e=%h m=%h g=%b s=%b sg=%b want e=%h m=%h g=%b s=%b sg=%b",
               tag, got.e, got.m, got.g, got.s, got.sg, want.e, want.m, want.g, want.s, want.sg);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      got = {norm_exponent, norm_mantissa, guard, sticky, sign};
      checks++;
      if (got !== want || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold[%0d]: got v=%b r=%b f=%h want v=1 r=0 f=%h",
                 tag, i, out_valid, in_ready, got, want);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: got v=%b r=%b want v=0 r=1", tag, out_valid, in_ready);
    end
    $display("op %-10s a=%h b=%h lat=%0d e=%h m=%h g=%b s=%b sg=%b",
             tag, av, bv, lat, got.e, got.m, got.g, got.s, got.sg);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || norm_exponent !== 10'd0 ||
        norm_mantissa !== 24'd0 || guard !== 1'b0 || sticky !== 1'b0 || sign !== 1'b0) begin
      errors++;
      $display("FAIL reset: got r=%b v=%b e=%h m=%h g=%b s=%b sg=%b want r=1 v=0 all zero",
               in_ready, out_valid, norm_exponent, norm_mantissa, guard, sticky, sign);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("reset done");
  endtask

  task automatic test_directed();
    logic [31:0] ta [6];
    logic [31:0] tb [6];
    res_t        tw [6];
    int          th [6];
    ta[0] = 32'h3FC00000; tb[0] = 32'h40000000; tw[0] = {10'd128, 24'hC00000, 1'b0, 1'b0, 1'b0}; th[0] = 0;
    ta[1] = 32'h3FC00000; tb[1] = 32'h3FC00000; tw[1] = {10'd128, 24'h900000, 1'b0, 1'b0, 1'b0}; th[1] = 0;
    ta[2] = 32'h3F800001; tb[2] = 32'h3F800001; tw[2] = {10'd127, 24'h800002, 1'b0, 1'b1, 1'b0}; th[2] = 0;
    ta[3] = 32'h3F800001; tb[3] = 32'h3FC00000; tw[3] = {10'd127, 24'hC00001, 1'b1, 1'b0, 1'b0}; th[3] = 0;
    ta[4] = 32'hBF800000; tb[4] = 32'h3F800000; tw[4] = {10'd127, 24'h800000, 1'b0, 1'b0, 1'b1}; th[4] = 10;
    // Zero times one: fields are zero in both builds, only latency differs.
    ta[5] = 32'h00000000; tb[5] = 32'h3F800000; tw[5] = {10'd0, 24'h000000, 1'b0, 1'b0, 1'b0}; th[5] = 2;
    for (int i = 0; i < 6; i++) run_op(ta[i], tb[i], tw[i], th[i], $sformatf("dir%0d", i));
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 5) == 0) x[30:23] = 8'd0;
      if ($urandom_range(0, 5) == 0) y[30:23] = 8'd0;
      run_op(x, y, model(x, y), $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 32'h3F800001; b = 32'h3FC00000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Now in MULT count 0; advance to count 10, then reset.
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || norm_mantissa !== 24'd0 ||
        norm_exponent !== 10'd0 || sign !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got r=%b v=%b m=%h e=%h sg=%b want r=1 v=0 zeros",
               in_ready, out_valid, norm_mantissa, norm_exponent, sign);
    end
    $display("reset mid-operation applied");
    run_op(32'h3FC00000, 32'h3FC00000, {10'd128, 24'h900000, 1'b0, 1'b0, 1'b0}, 0, "post_rst");
  endtask

  task automatic test_back_to_back();
    logic [31:0] x1, y1, x2, y2;
    res_t        got;
    int          vcyc, icyc, cyc;
    x1 = rand_normal(); y1 = rand_normal();
    x2 = rand_normal(); y2 = rand_normal();
    @(negedge clk);
    a = x1; b = y1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = x2; b = y2;
    vcyc = -1; icyc = -1; cyc = 1;
    while (cyc <= 60 && icyc < 0) begin
      if (out_valid === 1'b1) begin
        vcyc = cyc;
        got = {norm_exponent, norm_mantissa, guard, sticky, sign};
        checks++;
        if (got !== model(x1, y1)) begin
          errors++;
          $display("FAIL b2b_first: got %h want %h", got, model(x1, y1));
        end
      end
      if (in_ready === 1'b1) icyc = cyc;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    checks++;
    if (vcyc != 26 || icyc != 27) begin
      errors++;
      $display("FAIL b2b_timing: got valid@%0d ready@%0d want valid@26 ready@27", vcyc, icyc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    got = {norm_exponent, norm_mantissa, guard, sticky, sign};
    checks++;
    if (got !== model(x2, y2) || cyc != 26) begin
      errors++;
      $display("FAIL b2b_second: got %h lat=%0d want %h lat=26", got, cyc, model(x2, y2));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("op b2b a=%h b=%h then a=%h b=%h period=%0d", x1, y1, x2, y2, icyc);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
